// File: rtl/mulctl_pkg.sv
// rtl/mulctl_pkg.sv - shared types, defaults and helpers for the MUL sharing controller
package mulctl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH       = 16;
   localparam int DEF_MUL_LATENCY = 17;

   // a single requester still needs a one-bit ID field
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arb
   import mulctl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int ID_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);

   always_comb begin
      int   idx;
      logic found;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (en && !found && req[ID_W'(idx)]) begin
            found              = 1'b1;
            gnt[ID_W'(idx)]    = 1'b1;
            gnt_id             = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mul_share_ctl.sv
// rtl/mul_share_ctl.sv - shares one fixed-latency MUL between NUM_REQ requesters
// Optional zero-operand shortcut: MULCTL_ZERO_BYPASS_EN
module mul_share_ctl
   import mulctl_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MUL_LATENCY = DEF_MUL_LATENCY,
   parameter int ID_W        = clog2_min1(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] op_a,
   input  logic [NUM_REQ*WIDTH-1:0] op_b,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     busy,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   output logic                     mul_start,
   input  logic [2*WIDTH-1:0]       mul_s,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]       rsp_data
);

   localparam int CNT_W = $clog2(MUL_LATENCY + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  win_id;
   logic [WIDTH-1:0] win_a, win_b;
   logic             arb_en;
   logic             bypass;

   // grants only in IDLE and never while reset is held
   assign arb_en = (state == IDLE) && rst_n;

   rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .req    (req),
      .ptr    (rr_ptr),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_id (win_id)
   );

   assign win_a = op_a[win_id*WIDTH +: WIDTH];
   assign win_b = op_b[win_id*WIDTH +: WIDTH];

`ifdef MULCTL_ZERO_BYPASS_EN
   assign bypass = (win_a == '0) || (win_b == '0);
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      mul_start = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:    if (|gnt) state_nxt = bypass ? DONE : START;
         START: begin
            mul_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT:    if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rr_ptr   <= ID_W'(NUM_REQ - 1);
         mul_a    <= '0;
         mul_b    <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (|gnt) begin
               mul_a  <= win_a;
               mul_b  <= win_b;
               rsp_id <= win_id;
               rr_ptr <= win_id;
               if (bypass) rsp_data <= '0;
            end
            START: cnt <= CNT_W'(MUL_LATENCY);
            // MUL has no done flag; S is sampled on the last counted cycle
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) rsp_data <= mul_s;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_ctl.sv
// tb/tb_mul_share_ctl.sv - directed and random checks of mul_share_ctl against a reference model
module tb_mul_share_ctl;

   localparam int LAT = 17;
`ifdef MULCTL_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [31:0] op_a, op_b;
   logic [1:0]  gnt;
   logic        busy, mul_start, rsp_valid;
   logic [15:0] mul_a, mul_b;
   logic [31:0] mul_s = '0;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mctr  = 0;
   int lw    = 1;
   int prev_g = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_share_ctl #(.NUM_REQ(2), .WIDTH(16), .MUL_LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .busy      (busy),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_start (mul_start),
      .mul_s     (mul_s),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   // MUL stand-in: S is garbage until LAT cycles after the start cycle
   always @(posedge clk) begin
      if (mul_start) begin
         mctr  <= LAT - 1;
         mul_s <= 32'hDEAD_BEEF ^ $urandom;
      end else if (mctr > 0) begin
         mctr <= mctr - 1;
         if (mctr == 1) mul_s <= mul_a * mul_b;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [1:0] r);
      for (int k = 1; k <= 2; k++) begin
         int idx;
         idx = (lw + k) % 2;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic do_op(input logic [1:0] r, input bit hold, input bit gap_chk,
                        input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1);
      int w, lat, starts, first_start, exp_lat;
      bit zb, stable_ok, nogrant_ok, busy_ok;
      logic [31:0] ea, eb, ep;
      @(negedge clk);
      req  = r;
      op_a = {a1, a0};
      op_b = {b1, b0};
      #1;
      w  = rr_pick(r);
      ea = (w == 1) ? {16'h0, a1} : {16'h0, a0};
      eb = (w == 1) ? {16'h0, b1} : {16'h0, b0};
      ep = ea * eb;
      zb = BYP && (ea == 0 || eb == 0);
      exp_lat = zb ? 1 : 2 + LAT;
      chk("gnt_onehot", gnt, 64'(2'b01 << w));
      chk("busy_idle", busy, 0);
      if (gap_chk) chk("op_spacing", cyc - prev_g, LAT + 3);
      prev_g = cyc;
      lw = w;
      lat = -1; starts = 0; first_start = -1;
      stable_ok = 1; nogrant_ok = 1; busy_ok = 1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         if (!hold) begin
            req  = '0;
            op_a = $urandom;
            op_b = $urandom;
         end
         #1;
         if (mul_start) begin
            starts++;
            if (first_start < 0) first_start = c;
         end
         if (gnt !== 2'b00) nogrant_ok = 0;
         if (busy !== 1'b1) busy_ok = 0;
         if (mul_a !== ea[15:0] || mul_b !== eb[15:0]) stable_ok = 0;
         if (rsp_valid === 1'b1) lat = c;
      end
      chk("rsp_latency", lat, exp_lat);
      chk("rsp_id", rsp_id, w);
      chk("rsp_data", rsp_data, ep);
      chk("start_count", starts, zb ? 0 : 1);
      chk("start_cycle", first_start, zb ? -1 : 1);
      chk("operands_held", stable_ok, 1);
      chk("no_gnt_busy", nogrant_ok, 1);
      chk("busy_high", busy_ok, 1);
   endtask

   initial begin
      bit quiet_ok;
      rst_n = 1'b0;
      req   = '0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_start", mul_start, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_data", rsp_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(2'b01, 0, 0, 16'h1234, 16'h00FF, 16'h5555, 16'h7777);
      do_op(2'b10, 0, 0, 16'h1111, 16'h2222, 16'h0BCD, 16'h0002);

      do_op(2'b11, 1, 0, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h7FFF);
      do_op(2'b11, 1, 1, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h7FFF);
      do_op(2'b11, 1, 1, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h7FFF);
      do_op(2'b11, 1, 1, 16'hFFFF, 16'hFFFF, 16'h8001, 16'h7FFF);

      @(negedge clk);
      req = '0;
      #1;
      chk("hold_valid", rsp_valid, 0);
      chk("hold_busy", busy, 0);
      chk("hold_id", rsp_id, 1);
      chk("hold_data", rsp_data, 32'h8001 * 32'h7FFF);

      do_op(2'b01, 0, 0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000);

      // abort an operation five cycles after its start pulse
      @(negedge clk);
      req  = 2'b01;
      op_a = {16'h0, 16'h0005};
      op_b = {16'h0, 16'h0007};
      #1;
      chk("abort_gnt", gnt, 2'b01);
      @(negedge clk);
      req = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_mul_a", mul_a, 0);
      chk("abort_mul_b", mul_b, 0);
      chk("abort_start", mul_start, 0);
      chk("abort_valid", rsp_valid, 0);
      chk("abort_id", rsp_id, 0);
      chk("abort_data", rsp_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      quiet_ok = 1;
      repeat (25) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet_ok = 0;
      end
      chk("abort_quiet", quiet_ok, 1);
      lw = 1;
      do_op(2'b11, 0, 0, 16'h0003, 16'h0009, 16'h0004, 16'h0006);

      for (int i = 0; i < 10; i++) begin
         logic [1:0]  r;
         logic [15:0] a0, b0, a1, b1;
         r  = 2'($urandom_range(1, 3));
         a0 = 16'($urandom);
         b0 = 16'($urandom);
         a1 = 16'($urandom);
         b1 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) a0 = '0;
         if ($urandom_range(0, 3) == 0) b1 = '0;
         do_op(r, 0, 0, a0, b0, a1, b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_share_ctl.md
Name: mul_share_ctl

Overview:
- Sequencer/arbiter that shares the single multi-cycle 16x16 MUL unit between NUM_REQ requesters, e.g. the CPU execute stage and the address-generation path.
- MUL has no done flag; this block issues its one-cycle start pulse, holds its operands stable, counts a fixed latency, then captures S.
- The captured product is returned to the winning requester with a valid pulse and requester ID.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 16, operand width; product is 2*WIDTH.
- MUL_LATENCY, 17, cycles from the MUL start cycle until S is guaranteed stable.
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester ID.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- op_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b  in  NUM_REQ*WIDTH  packed operand B; same packing as op_a.
- gnt  out  NUM_REQ  one-hot accept pulse; operands are sampled on this edge.
- busy  out  1  high in every state except IDLE.
- mul_a  out  WIDTH  operand A to MUL.
- mul_b  out  WIDTH  operand B to MUL.
- mul_start  out  1  one-cycle start pulse to MUL.
- mul_s  in  2*WIDTH  product from MUL.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_data  out  2*WIDTH  product.

Behaviour:
- Reset values: gnt=0, busy=0, mul_a=0, mul_b=0, mul_start=0, rsp_valid=0, rsp_id=0, rsp_data=0, state=IDLE, cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first).
- FSM states: IDLE -> START -> WAIT -> DONE -> IDLE.
- IDLE:
  - If req!=0, gnt is driven combinationally, one-hot, to the round-robin winner.
  - Winner = first set bit searching from rr_ptr+1 upward, wrapping.
  - On that edge: mul_a/mul_b <= winner's operands, rsp_id <= winner, rr_ptr <= winner, go to START.
  - If req==0, stay in IDLE.
- START: mul_start=1 for exactly one cycle; cnt <= MUL_LATENCY; go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, rsp_data <= mul_s and go to DONE.
- DONE: rsp_valid=1 for one cycle; go to IDLE.
- Latency: if gnt is high in cycle t, mul_start is high in t+1 and rsp_valid is high in t+2+MUL_LATENCY.
- Throughput: one operation per MUL_LATENCY+3 cycles, with a one-cycle bubble after DONE.
- mul_a/mul_b hold constant from START through DONE and are not cleared afterwards.
- Requester rules:
  - Hold req and operands stable until gnt.
  - req may be withdrawn before gnt without effect.
  - Operands are not needed after gnt.
- Requests while busy=1 are ignored; gnt stays 0 and nothing is queued.
- The same requester may re-request in the IDLE cycle after its rsp_valid.
- Product is unsigned, full 2*WIDTH bits, no truncation.
- Reset asserted mid-operation: immediate return to reset values. The in-flight result is dropped, no rsp_valid is issued, and the MUL internal state is don't-care.
- rsp_data/rsp_id hold their last values after the rsp_valid pulse.

Optional Feature:
- MULCTL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the winner's op_a==0 or op_b==0, go directly to DONE with rsp_data <= 0.
  - mul_start is not pulsed.
  - gnt is in t, rsp_valid in t+1.
  - mul_a/mul_b are still loaded.
- Undefined: zero operands follow the full START/WAIT sequence.

Decomposition:
- Package mulctl_pkg:
  - state encoding constants (IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3);
  - default WIDTH and MUL_LATENCY constants;
  - function clog2_min1.
- Sub-module rr_arb:
  - parameter NUM_REQ;
  - inputs req, ptr, en;
  - outputs one-hot gnt and binary gnt_id.
  - Purely combinational; rr_ptr storage stays in mul_share_ctl.

Test Plan:
- Single request, requester 0 with A=0x1234, B=0x00FF: gnt[0] in t; mul_start in t+1 only; rsp_valid in t+19 with rsp_id=0, rsp_data=0x001221CC.
- Requester 1 with A=0x0BCD, B=0x0002: rsp_id=1, rsp_data=0x0000179A; mul_a/mul_b stable until DONE.
- Both requests held high for 4 operations: grants go 0,1,0,1; busy high between; no gnt while busy; each operation 20 cycles apart.
- A=0xFFFF, B=0xFFFF: rsp_data=0xFFFE0001, full-width check.
- rst_n pulled low 5 cycles after mul_start: all outputs at reset values immediately; no rsp_valid; next request granted to requester 0.
- A=0x0000, B=0xABCD: with MULCTL_ZERO_BYPASS_EN, rsp_valid at t+1 with 0 and no mul_start; without it, rsp_valid at t+19 with 0.
